// File: rtl/aes_inv_col_mux.sv
// AES InvMixColumns engine: one column per clock through a shared GF(2^8) datapath,
// with a one-cycle result pulse on out/out_flag.
module aes_inv_col_mux (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in,
  input  logic         inv_mix_en,
  output logic [127:0] out,
  output logic         out_flag,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    COL0 = 3'd1,
    COL1 = 3'd2,
    COL2 = 3'd3,
    COL3 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   res_q, res_d;
  logic [127:0]   out_q, out_d;
  logic           flag_q, flag_d;
  logic [31:0]    col_in;
  logic [31:0]    col_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse column mix: every coefficient is assembled from the 2x/4x/8x chain.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    col_in = 32'h0;
    case (state_q)
      COL0:    col_in = data_q[127:96];
      COL1:    col_in = data_q[95:64];
      COL2:    col_in = data_q[63:32];
      COL3:    col_in = data_q[31:0];
      default: col_in = 32'h0;
    endcase
  end

  assign col_out = inv_col(col_in);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    data_d  = data_q;
    res_d   = res_q;
    out_d   = 128'h0;
    flag_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_mix_en) begin
          data_d  = in;
          res_d   = 128'h0;
          state_d = COL0;
        end
      end
      COL0: begin
        res_d[127:96] = col_out;
        state_d       = COL1;
      end
      COL1: begin
        res_d[95:64] = col_out;
        state_d      = COL2;
      end
      COL2: begin
        res_d[63:32] = col_out;
        state_d      = COL3;
      end
      COL3: begin
        res_d[31:0] = col_out;
        state_d     = DONE;
      end
      DONE: begin
        out_d   = res_q;
        flag_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the data and result registers are plain flops, not RAM, so they are reset with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 128'h0;
      res_q   <= 128'h0;
      out_q   <= 128'h0;
      flag_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      data_q  <= data_d;
      res_q   <= res_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
    end
  end

  assign out      = out_q;
  assign out_flag = flag_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_aes_inv_col_mux.sv
// Self-checking bench for aes_inv_col_mux: directed vectors plus a random round trip
// through a behavioural forward/inverse MixColumns model.
module tb_aes_inv_col_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic         inv_mix_en;
  logic [127:0] out;
  logic         out_flag;
  logic         busy;

  int checks = 0;
  int errors = 0;

  aes_inv_col_mux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_data),
    .inv_mix_en (inv_mix_en),
    .out        (out),
    .out_flag   (out_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: generic shift-and-add GF(2^8) product and the MixColumns matrices.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
    logic [7:0] coef [4];
    logic [127:0] r = 128'h0;
    logic [7:0] acc;
    if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h0;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(coef[(j - i + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        r[127 - 8*(4*c + i) -: 8] = acc;
      end
    return r;
  endfunction

  // Pulse en for one edge, then wait (bounded) for the result pulse and check it.
  task automatic do_op(input logic [127:0] d, input logic [127:0] exp, input string tag);
    int lat;
    @(negedge clk);
    in_data    = d;
    inv_mix_en = 1'b1;
    @(negedge clk);
    inv_mix_en = 1'b0;
    in_data    = ~d;
    lat = 0;
    while (!out_flag && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'd5);
    check({tag, "_out"}, out, exp);
    @(negedge clk);
    check({tag, "_pulse_width"}, {out_flag, out}, 129'h0);
  endtask

  logic [127:0] s, a_val, b_val;
  int flag_t [2];
  logic [127:0] flag_v [2];
  int nflags;

  initial begin
    rst_n      = 1'b0;
    inv_mix_en = 1'b0;
    in_data    = 128'h0;
    #12;
    check("reset_outputs", {out_flag, busy, out}, 130'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {out_flag, busy, out}, 130'h0);

    // Known vectors
    do_op(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
          128'hdb135345_f20a225c_01010101_d4d4d4d5, "known_vec");
    do_op(128'hc6c6c6c6_00000000_01010101_4d7ebdf8,
          128'hc6c6c6c6_00000000_01010101_2d26314c, "ident_zero");
    check("model_vs_known",
          mix(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b1),
          128'hdb135345_f20a225c_01010101_d4d4d4d5);

    // Busy protection: a second request in COL1 must be ignored
    a_val = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    b_val = 128'hdead_beef_cafe_f00d_1234_5678_9abc_def0;
    @(negedge clk);
    in_data = a_val; inv_mix_en = 1'b1;
    @(negedge clk);                       // after accept edge: COL0
    inv_mix_en = 1'b0;
    @(negedge clk);                       // COL1
    check("busy_in_col1", 128'(busy), 128'd1);
    in_data = b_val; inv_mix_en = 1'b1;
    @(negedge clk);
    inv_mix_en = 1'b0;
    @(negedge clk);                       // COL3
    @(negedge clk);                       // DONE
    check("busy_before_flag", {out_flag, busy}, 2'b01);
    @(negedge clk);
    check("busy_prot_flag", {out_flag, busy}, 2'b10);
    check("busy_prot_out", out, mix(a_val, 1'b1));
    nflags = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_flag) nflags++;
    end
    check("busy_prot_no_second", 128'(nflags), 128'd0);

    // Back-to-back with en held high
    a_val = {$urandom, $urandom, $urandom, $urandom};
    b_val = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_data = a_val; inv_mix_en = 1'b1;
    @(negedge clk);
    in_data = b_val;
    nflags = 0;
    for (int t = 1; t < 30 && nflags < 2; t++) begin
      if (out_flag) begin
        flag_t[nflags] = t;
        flag_v[nflags] = out;
        nflags++;
        if (nflags == 2) inv_mix_en = 1'b0;
      end
      if (nflags < 2) @(negedge clk);
    end
    inv_mix_en = 1'b0;
    check("b2b_flag_count", 128'(nflags), 128'd2);
    if (nflags == 2) begin
      check("b2b_spacing", 128'(flag_t[1] - flag_t[0]), 128'd6);
      check("b2b_first", flag_v[0], mix(a_val, 1'b1));
      check("b2b_second", flag_v[1], mix(b_val, 1'b1));
    end
    repeat (8) @(negedge clk);
    check("b2b_idle_after", {out_flag, busy, out}, 130'h0);

    // Reset mid-operation in COL2
    @(negedge clk);
    in_data = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6; inv_mix_en = 1'b1;
    @(negedge clk);                       // COL0
    inv_mix_en = 1'b0;
    @(negedge clk);                       // COL1
    @(negedge clk);                       // COL2
    check("busy_in_col2", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", {out_flag, busy, out}, 130'h0);
    nflags = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_flag) nflags++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_flag) nflags++;
    end
    check("reset_no_flag", 128'(nflags), 128'd0);
    do_op(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
          128'hdb135345_f20a225c_01010101_d4d4d4d5, "restart");

    // Random round trip: forward mix in the model, inverse in the DUT
    for (int n = 0; n < 1000; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      do_op(mix(s, 1'b0), s, "round_trip");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
